// File: rtl/port_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : port_allocator
//  Description : Five-port wormhole switch allocator. One round-robin
//                allocator per output locks that output to a packet from
//                HEADER to TAIL and steers the crossbar from its owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module port_allocator #(
  parameter logic [2:0] HEADER_ID  = 3'd1,
  parameter logic [2:0] PAYLOAD_ID = 3'd2,
  parameter logic [2:0] TAIL_ID    = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  in_valid,
  input  logic [14:0] in_flit_id,
  input  logic [24:0] in_req,
  input  logic [4:0]  out_credit,
  output logic [4:0]  in_rd_en,
  output logic [4:0]  out_wr_en,
  output logic [14:0] xbar_sel,
  output logic [4:0]  out_busy
);

  localparam int NUM_PORTS = 5;
  localparam int PORT_L    = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alloc_state_t;

  alloc_state_t state_q [NUM_PORTS];
  alloc_state_t state_d [NUM_PORTS];
  logic [2:0]   owner_q [NUM_PORTS];
  logic [2:0]   owner_d [NUM_PORTS];
  logic [2:0]   ptr_q   [NUM_PORTS];
  logic [2:0]   ptr_d   [NUM_PORTS];

  logic [4:0]   in_locked;   // input currently owns a busy output
  logic [4:0]   req_ok;      // input presents a grantable header
  logic [4:0]   win_found;
  logic [2:0]   winner  [NUM_PORTS];
  logic [4:0]   fwd;         // flit moves through output o this cycle
  logic [4:0]   tail_fwd;    // that flit is the packet tail

  // Round-robin search position: (ptr + step) mod 5
  function automatic logic [2:0] rr_index(input logic [2:0] ptr, input int step);
    int sum;
    sum = int'(ptr) + step;
    return 3'(sum % NUM_PORTS);
  endfunction

  // Qualify each input: valid one-hot header from an input not already locked
  always_comb begin
    in_locked = '0;
    req_ok    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (state_q[o] == ST_BUSY && owner_q[o] == 3'(i)) begin
          in_locked[i] = 1'b1;
        end
      end
      req_ok[i] = in_valid[i] && (in_flit_id[3*i +: 3] == HEADER_ID) &&
                  $onehot(in_req[5*i +: 5]) && !in_locked[i];
    end
  end

  // Per-output round-robin search starting one past the pointer
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      win_found[o] = 1'b0;
      winner[o]    = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (!win_found[o] && 3'(i) == rr_index(ptr_q[o], k) && req_ok[i] &&
              in_req[5*i + o] && (o == PORT_L || i != o)) begin
            win_found[o] = 1'b1;
            winner[o]    = 3'(i);
          end
        end
      end
    end
  end

  // Combinational forwarding for locked outputs; everything quiet in reset
  always_comb begin
    in_rd_en  = '0;
    out_wr_en = '0;
    xbar_sel  = '0;
    out_busy  = '0;
    fwd       = '0;
    tail_fwd  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == ST_BUSY) begin
        out_busy[o]          = 1'b1;
        xbar_sel[3*o +: 3]   = owner_q[o];
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (owner_q[o] == 3'(i)) begin
            fwd[o]      = in_valid[i] && out_credit[o];
            tail_fwd[o] = fwd[o] && (in_flit_id[3*i +: 3] == TAIL_ID);
            in_rd_en[i] = in_rd_en[i] | fwd[o];
          end
        end
      end
    end
    out_wr_en = fwd;
    if (rst) begin
      in_rd_en  = '0;
      out_wr_en = '0;
      xbar_sel  = '0;
      out_busy  = '0;
      fwd       = '0;
      tail_fwd  = '0;
    end
  end

  // Next state: grant when idle, release and advance pointer on tail
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (state_q[o] == ST_IDLE) begin
        if (win_found[o]) begin
          state_d[o] = ST_BUSY;
          owner_d[o] = winner[o];
        end
      end else if (tail_fwd[o]) begin
        state_d[o] = ST_IDLE;
        ptr_d[o]   = owner_q[o];
      end
    end
  end

  // State registers; pointer resets to L so the first search starts at N
  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (rst) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= 3'd0;
        ptr_q[o]   <= 3'd4;
      end else begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_port_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_port_allocator
//  Description : Self-checking bench for port_allocator. Input FIFOs are
//                modelled as queues; a queue-based reference model checks
//                randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_port_allocator;

  localparam logic [2:0] HDR = 3'd1;
  localparam logic [2:0] PAY = 3'd2;
  localparam logic [2:0] TL  = 3'd3;

  logic        clk;
  logic        rst;
  logic [4:0]  in_valid;
  logic [14:0] in_flit_id;
  logic [24:0] in_req;
  logic [4:0]  out_credit;
  logic [4:0]  in_rd_en;
  logic [4:0]  out_wr_en;
  logic [14:0] xbar_sel;
  logic [4:0]  out_busy;

  int n_checks;
  int n_errors;

  logic [2:0] q_type [5][$];
  logic [4:0] q_req  [5][$];

  port_allocator #(
    .HEADER_ID  (HDR),
    .PAYLOAD_ID (PAY),
    .TAIL_ID    (TL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_flit_id (in_flit_id),
    .in_req     (in_req),
    .out_credit (out_credit),
    .in_rd_en   (in_rd_en),
    .out_wr_en  (out_wr_en),
    .xbar_sel   (xbar_sel),
    .out_busy   (out_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_packet(input int src, input logic [4:0] req, input int len);
    q_type[src].push_back(HDR);
    q_req[src].push_back(req);
    for (int k = 0; k < len - 2; k++) begin
      q_type[src].push_back(PAY);
      q_req[src].push_back(req);
    end
    q_type[src].push_back(TL);
    q_req[src].push_back(req);
  endtask

  task automatic flush_fifos();
    for (int i = 0; i < 5; i++) begin
      q_type[i].delete();
      q_req[i].delete();
    end
  endtask

  task automatic drive_inputs();
    in_valid   = '0;
    in_flit_id = '0;
    in_req     = '0;
    for (int i = 0; i < 5; i++) begin
      if (q_type[i].size() > 0) begin
        in_valid[i]          = 1'b1;
        in_flit_id[3*i +: 3] = q_type[i][0];
        in_req[5*i +: 5]     = q_req[i][0];
      end
    end
  endtask

  task automatic pop_fifos(input logic [4:0] mask);
    for (int i = 0; i < 5; i++) begin
      if (mask[i] && q_type[i].size() > 0) begin
        void'(q_type[i].pop_front());
        void'(q_req[i].pop_front());
      end
    end
  endtask

  // Ends at a falling edge with rst just released
  task automatic reset_dut();
    rst = 1'b1;
    flush_fifos();
    out_credit = '1;
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] exp_v;
    rst = 1'b1;
    flush_fifos();
    push_packet(0, 5'b00010, 2);
    out_credit = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_inputs();
      #1;
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== 30'd0) begin
        n_errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", c, {out_busy, out_wr_en, in_rd_en, xbar_sel});
      end
    end
    rst = 1'b0;
    // idle after reset, then N->E for two flits, then idle again
    for (int c = 0; c < 4; c++) begin
      drive_inputs();
      #1;
      exp_v = (c == 1 || c == 2) ? {5'b00010, 5'b00010, 5'b00001, 15'h0000} : 30'd0;
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== exp_v) begin
        n_errors++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", c, {out_busy, out_wr_en, in_rd_en, xbar_sel}, exp_v);
      end
      pop_fifos(in_rd_en);
      @(negedge clk);
    end
  endtask

  task automatic test_single_packet();
    logic [29:0] exp_v;
    reset_dut();
    push_packet(4, 5'b00010, 3);
    for (int c = 0; c < 5; c++) begin
      drive_inputs();
      #1;
      exp_v = (c >= 1 && c <= 3) ? {5'b00010, 5'b00010, 5'b10000, 15'h0020} : 30'd0;
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== exp_v) begin
        n_errors++;
        $display("FAIL single_packet cyc=%0d got=%h exp=%h", c, {out_busy, out_wr_en, in_rd_en, xbar_sel}, exp_v);
      end
      pop_fifos(in_rd_en);
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int own [12] = '{-1, 0, 0, -1, 2, 2, -1, 3, 3, -1, 0, 0};
    logic [29:0] exp_v;
    reset_dut();
    for (int r = 0; r < 2; r++) begin
      push_packet(0, 5'b10000, 2);
      push_packet(2, 5'b10000, 2);
      push_packet(3, 5'b10000, 2);
    end
    for (int c = 0; c < 12; c++) begin
      drive_inputs();
      #1;
      if (own[c] < 0) exp_v = 30'd0;
      else exp_v = {5'b10000, 5'b10000, 5'(1 << own[c]), 15'(own[c] << 12)};
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== exp_v) begin
        n_errors++;
        $display("FAIL round_robin cyc=%0d got=%h exp=%h", c, {out_busy, out_wr_en, in_rd_en, xbar_sel}, exp_v);
      end
      pop_fifos(in_rd_en);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [29:0] exp_v;
    logic        busy_c;
    logic        move_c;
    reset_dut();
    push_packet(2, 5'b00010, 4);
    for (int c = 0; c < 10; c++) begin
      out_credit    = '1;
      out_credit[1] = !(c >= 3 && c <= 6);
      drive_inputs();
      #1;
      busy_c = (c >= 1 && c <= 8);
      move_c = (c >= 1 && c <= 2) || (c >= 7 && c <= 8);
      exp_v  = {busy_c ? 5'b00010 : 5'b0, move_c ? 5'b00010 : 5'b0,
                move_c ? 5'b00100 : 5'b0, busy_c ? 15'h0010 : 15'h0};
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== exp_v) begin
        n_errors++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, {out_busy, out_wr_en, in_rd_en, xbar_sel}, exp_v);
      end
      pop_fifos(in_rd_en);
      @(negedge clk);
    end
    out_credit = '1;
  endtask

  task automatic test_parallel();
    logic [29:0] exp_v;
    reset_dut();
    push_packet(0, 5'b01000, 3);
    push_packet(3, 5'b00001, 3);
    for (int c = 0; c < 5; c++) begin
      drive_inputs();
      #1;
      exp_v = (c >= 1 && c <= 3) ? {5'b01001, 5'b01001, 5'b01001, 15'h0003} : 30'd0;
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== exp_v) begin
        n_errors++;
        $display("FAIL parallel cyc=%0d got=%h exp=%h", c, {out_busy, out_wr_en, in_rd_en, xbar_sel}, exp_v);
      end
      pop_fifos(in_rd_en);
      @(negedge clk);
    end
  endtask

  task automatic test_masking();
    reset_dut();
    push_packet(1, 5'b00010, 2);
    push_packet(0, 5'b00110, 2);
    for (int c = 0; c < 4; c++) begin
      drive_inputs();
      #1;
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== 30'd0) begin
        n_errors++;
        $display("FAIL masking cyc=%0d got=%h exp=0", c, {out_busy, out_wr_en, in_rd_en, xbar_sel});
      end
      pop_fifos(in_rd_en);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [29:0] exp_v;
    reset_dut();
    push_packet(0, 5'b00010, 4);
    for (int c = 0; c < 8; c++) begin
      rst = (c == 3);
      drive_inputs();
      #1;
      exp_v = (c >= 1 && c <= 2) ? {5'b00010, 5'b00010, 5'b00001, 15'h0000} : 30'd0;
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid_packet cyc=%0d got=%h exp=%h", c, {out_busy, out_wr_en, in_rd_en, xbar_sel}, exp_v);
      end
      pop_fifos(in_rd_en);
      @(negedge clk);
    end
    rst = 1'b0;
    n_checks++;
    if (q_type[0].size() !== 2) begin
      n_errors++;
      $display("FAIL reset_mid_leftover got=%0d exp=2", q_type[0].size());
    end
  endtask

  // Randomized traffic against a packet-level reference model
  task automatic test_random();
    int          m_busy  [5];
    int          m_owner [5];
    int          m_ptr   [5];
    int          grant   [5];
    bit          locked  [5];
    logic [4:0]  e_rd, e_wr, e_busy;
    logic [14:0] e_sel;
    int          d, idx;
    reset_dut();
    for (int o = 0; o < 5; o++) begin
      m_busy[o]  = 0;
      m_owner[o] = 0;
      m_ptr[o]   = 4;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (q_type[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          d = $urandom_range(0, 4);
          if (d == i && i != 4) d = 4;
          push_packet(i, 5'(1 << d), $urandom_range(2, 5));
        end
      end
      out_credit = 5'($urandom()) | 5'($urandom());
      drive_inputs();
      #1;
      e_rd = '0; e_wr = '0; e_busy = '0; e_sel = '0;
      for (int i = 0; i < 5; i++) locked[i] = 0;
      for (int o = 0; o < 5; o++) if (m_busy[o] != 0) locked[m_owner[o]] = 1;
      for (int o = 0; o < 5; o++) begin
        grant[o] = -1;
        if (m_busy[o] != 0) begin
          e_busy[o]          = 1'b1;
          e_sel[3*o +: 3]    = 3'(m_owner[o]);
          if (q_type[m_owner[o]].size() > 0 && out_credit[o]) begin
            e_wr[o]          = 1'b1;
            e_rd[m_owner[o]] = 1'b1;
          end
        end else begin
          for (int k = 1; k <= 5; k++) begin
            idx = (m_ptr[o] + k) % 5;
            if (grant[o] < 0 && q_type[idx].size() > 0 && q_type[idx][0] == HDR &&
                q_req[idx][0] == 5'(1 << o) && !locked[idx] && (o == 4 || idx != o))
              grant[o] = idx;
          end
        end
      end
      n_checks++;
      if ({out_busy, out_wr_en, in_rd_en, xbar_sel} !== {e_busy, e_wr, e_rd, e_sel}) begin
        n_errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, {out_busy, out_wr_en, in_rd_en, xbar_sel}, {e_busy, e_wr, e_rd, e_sel});
      end
      for (int o = 0; o < 5; o++) begin
        if (m_busy[o] != 0) begin
          if (e_wr[o] && q_type[m_owner[o]][0] == TL) begin
            m_busy[o] = 0;
            m_ptr[o]  = m_owner[o];
          end
        end else if (grant[o] >= 0) begin
          m_busy[o]  = 1;
          m_owner[o] = grant[o];
        end
      end
      pop_fifos(e_rd);
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = '0;
    in_flit_id = '0;
    in_req     = '0;
    out_credit = '1;
    n_checks   = 0;
    n_errors   = 0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_parallel();
    test_masking();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/port_allocator.md
PORT_ALLOCATOR -- requirements
Module: port_allocator

Interface
REQ-001 Port list, clock and reset first: clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 rst, input, 1, synchronous, active-high reset, sampled on rising clk.
REQ-003 in_valid, input, 5, per input port: head flit of that input FIFO valid (~empty). Bit order for all 5-bit port vectors: [0]=N, [1]=E, [2]=W, [3]=S, [4]=L.
REQ-004 in_flit_id, input, 15, per input 3-bit flit type; input i uses bits [3i+2:3i]; HEADER/PAYLOAD/TAIL encodings from the shared parameters file.
REQ-005 in_req, input, 25, per input one-hot output-port request from that input's routing unit; input i uses bits [5i+4:5i], same bit order as REQ-003.
REQ-006 out_credit, input, 5, per output: downstream can accept one flit this cycle.
REQ-007 in_rd_en, output, 5, per input: pop head flit this cycle.
REQ-008 out_wr_en, output, 5, per output: crossbar drives a valid flit this cycle.
REQ-009 xbar_sel, output, 15, per output 3-bit index (0..4) of the connected input; output o uses bits [3o+2:3o].
REQ-010 out_busy, output, 5, per output: output locked to a packet.

Function
REQ-011 One independent allocator per output; each holds state IDLE or BUSY, a 3-bit owner index and a 3-bit round-robin pointer.
REQ-012 Eligible requester for output o in IDLE: input i with in_valid[i]=1, in_flit_id_i=HEADER, in_req bit o set, i not owning any BUSY output, and i!=o for o in N/E/W/S (U-turn masked; L->L allowed).
REQ-013 Arbitration: among eligible inputs, grant the first found searching from (pointer+1) mod 5 upward with wrap; all five outputs arbitrate in the same cycle.
REQ-014 Simultaneous grant conflict impossible: each input requests one output (one-hot); a non-one-hot in_req is ignored for that input (no grant).
REQ-015 IDLE->BUSY on the clock edge after an eligible request exists; owner<=winner; request-to-out_busy latency 1 cycle; no flit moves in the arbitration cycle.
REQ-016 In BUSY, forwarding is combinational: out_wr_en[o]=in_rd_en[owner]=in_valid[owner] & out_credit[o]; xbar_sel=owner whenever BUSY.
REQ-017 out_credit[o]=0 or in_valid[owner]=0 -> stall: no pop, no write, state held, owner held.
REQ-018 BUSY->IDLE on the edge where a flit with flit_id=TAIL is forwarded; pointer<=owner on that edge; output may be re-granted from the next cycle (one idle cycle between packets).
REQ-019 Header flit is forwarded as first flit in BUSY; packets are at least two flits (HEADER ... TAIL); a HEADER arriving while BUSY is forwarded as data and does not release.
REQ-020 IDLE outputs: out_wr_en=0, xbar_sel=0, out_busy=0; inputs not owning a BUSY output: in_rd_en=0.
REQ-021 Pointer updates only on packet completion; never changes while IDLE or stalled.

Reset
REQ-022 rst=1 on an edge: all allocators IDLE, owners=0, pointers=4 (so first search starts at N), regardless of packets in flight.
REQ-023 While rst=1 all outputs (in_rd_en, out_wr_en, xbar_sel, out_busy) are 0; arbitration resumes the first cycle after rst deasserts.
REQ-024 Reset mid-packet drops the connection; remaining flits of that packet are not granted until a new HEADER is presented.

Verification
REQ-025 Single packet: after reset, input L HEADER req=E, credit=1, 3-flit packet -> out_busy[E]=1 next cycle, xbar_sel E=4, 3 consecutive in_rd_en[4]/out_wr_en[E] pulses, out_busy[E]=0 after TAIL edge.
REQ-026 Round robin: inputs N,W,S all HEADER req=L continuously, 2-flit packets -> grant order N, W, S, N with one idle cycle between packets.
REQ-027 Backpressure: BUSY E, out_credit[E]=0 for 4 cycles mid-packet -> no in_rd_en/out_wr_en for those cycles, owner unchanged, resumes when credit=1.
REQ-028 Parallel: N->S and S->N requested same cycle -> both outputs BUSY next cycle, both forward concurrently.
REQ-029 Masking: input E HEADER req=E, and req=5'b00110 from input N -> no grant to either.
REQ-030 Reset mid-packet: rst pulsed after 2 flits of 4 -> all outputs IDLE, out_busy=0; PAYLOAD from that input not forwarded afterwards.
